// File: rtl/demux_pkg.sv
//------------------------------------------------------------------------------
// Module   : demux_pkg
// Purpose  : Shared types and constants for the demux1x8_deser block:
//            FSM state type, default lane count, and lane ordering
//            (start lane / last lane) for LSB-first or MSB-first assembly.
// Config   : DEMUX_MSB_FIRST_EN - when defined, lanes fill from WIDTH-1
//            down to 0; otherwise from 0 up to WIDTH-1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int c_WIDTH_DEF = 8;

`ifdef DEMUX_MSB_FIRST_EN
  localparam bit c_MSB_FIRST = 1'b1;
`else
  localparam bit c_MSB_FIRST = 1'b0;
`endif

  // Lane written by the first bit of a word.
  function automatic int lane_start(input int width);
    return c_MSB_FIRST ? (width - 1) : 0;
  endfunction

  // Lane written by the final bit of a word.
  function automatic int lane_last(input int width);
    return c_MSB_FIRST ? 0 : (width - 1);
  endfunction

  localparam int c_LANE_START = lane_start(c_WIDTH_DEF);
  localparam int c_LANE_LAST  = lane_last(c_WIDTH_DEF);

endpackage

`default_nettype wire

// File: rtl/demux_sel_cnt.sv
//------------------------------------------------------------------------------
// Module   : demux_sel_cnt
// Purpose  : Lane counter for the deserializer. Holds the index of the lane
//            the next accepted bit is written to. Saturates at the last lane
//            (never wraps); the owner reloads it to the start lane.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset (sel -> start lane)
//            load - reload sel with the start lane (priority over step)
//            step - advance sel by one lane toward the last lane
//            sel  - current lane index (registered)
//            last - sel is at the last lane
// Config   : DEMUX_MSB_FIRST_EN selects counting direction (via demux_pkg).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_sel_cnt
  import demux_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  localparam logic [SEL_W-1:0] c_START = SEL_W'(lane_start(WIDTH));
  localparam logic [SEL_W-1:0] c_LAST  = SEL_W'(lane_last(WIDTH));
  localparam logic [SEL_W-1:0] c_ONE   = SEL_W'(1);

  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_next;

  assign w_next = c_MSB_FIRST ? (r_sel - c_ONE) : (r_sel + c_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= c_START;
    end else if (load) begin
      r_sel <= c_START;
    end else if (step && !last) begin
      // Stepping on the last lane is ignored so the index never wraps.
      r_sel <= w_next;
    end
  end

  assign sel  = r_sel;
  assign last = (r_sel == c_LAST);

endmodule

`default_nettype wire

// File: rtl/demux1x8_deser.sv
//------------------------------------------------------------------------------
// Module   : demux1x8_deser
// Purpose  : Serial-to-parallel 1:WIDTH demultiplexer. Each accepted serial
//            bit is written to lane dout[sel]; after the last lane the word
//            is held with dout_valid until downstream takes it.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            din        - serial data bit
//            din_valid  - din is valid
//            din_ready  - block accepts a bit this cycle (state decoded)
//            dout       - assembled word (registered)
//            dout_valid - dout holds a complete word (registered)
//            dout_ready - downstream consumes the word
//            sel        - lane the next accepted bit goes to (registered)
// Config   : DEMUX_MSB_FIRST_EN - fill lanes MSB-first instead of LSB-first.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux1x8_deser
  import demux_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] sel
);

  state_t           r_state;
  logic             w_accept;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_lane_we;

  // Ready depends only on state, so there is no path from din_valid.
  assign din_ready = (r_state != HOLD);
  assign w_accept  = din_valid && din_ready;
  assign w_load    = (r_state == HOLD) && dout_ready;

  demux_sel_cnt #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_sel_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_accept),
    .sel  (sel),
    .last (w_last)
  );

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign w_lane_we[i] = w_accept && (sel == SEL_W'(i));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      // Only the addressed lane changes; other lanes keep their old bits.
      dout <= (dout & ~w_lane_we) | ({WIDTH{din}} & w_lane_we);

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= FILL;
          end
        end
        FILL: begin
          if (w_accept && w_last) begin
            r_state    <= HOLD;
            dout_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (dout_ready) begin
            r_state    <= IDLE;
            dout_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/demux1x8_deser.md
# demux1x8_deser

Sequential 1-to-8 demultiplexer that accepts a serial bit stream and assembles it into an 8-bit parallel word. Each accepted bit is written to lane `dout[sel]`, and an internal lane counter advances `sel` after every accepted bit. This makes the block the receive-side inverse of the 8:1 select path. A valid/ready handshake on each side gives upstream backpressure and downstream word delivery.

## Interface
- `WIDTH`, default 8: number of output lanes (bits per word). Tests use 8.
- `SEL_W`, default `$clog2(WIDTH)`: width of the lane index.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din` input 1: serial data bit.
- `din_valid` input 1: `din` is valid this cycle.
- `din_ready` output 1: block can accept a bit this cycle.
- `dout` output WIDTH: assembled parallel word (registered).
- `dout_valid` output 1: `dout` holds a complete word.
- `dout_ready` input 1: downstream consumes the word.
- `sel` output SEL_W: lane the next accepted bit will be written to.

## Operation
- A bit is accepted on a rising edge when `din_valid && din_ready`.
- FSM states:
  - IDLE: `sel`=0. An accept writes `dout[sel]` and moves to FILL.
  - FILL: each accept writes `dout[sel]` and advances `sel` by one.
    - The accept that writes the final lane moves to HOLD.
    - No accept means hold state; `din_valid` gaps are allowed anywhere.
  - HOLD: `dout_valid`=1 and `din_ready`=0. `dout_ready`=1 moves to IDLE and resets `sel` to its start value.
- `din_ready` is 1 in IDLE and FILL and 0 in HOLD. It is decoded from state, with no combinational path from `din_valid`.
- `dout` is never cleared between words; every lane is overwritten during FILL. Lanes not yet written in the current word keep the previous word's bits. Consumers use `dout` only when `dout_valid`=1.
- `dout` is stable for the whole HOLD period.
- Counter wrap: the lane counter never wraps silently. Reaching the last lane forces HOLD.
- HOLD with `dout_ready`=1 and `din_valid`=1 in the same cycle: the bit is NOT accepted because `din_ready`=0. It is accepted in the following cycle in IDLE.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `sel`=0 (or WIDTH-1 with the macro), state IDLE, `din_ready`=1 once `rst` deasserts.
- Reset mid-word or in HOLD: the partial or held word is discarded immediately, asynchronously.
- Latency: `dout_valid` rises on the same edge that captures the WIDTH-th bit.
  - Minimum word period is WIDTH+1 cycles: WIDTH accepts plus one HOLD cycle with `dout_ready`=1.
- `dout_valid` falls on the edge where HOLD sees `dout_ready`=1.
- All outputs are registered except `din_ready`, which is state-decoded.

## Configuration
- `DEMUX_MSB_FIRST_EN` defined:
  - `sel` starts at WIDTH-1 and decrements; the first received bit lands in `dout[WIDTH-1]`.
  - The last lane is 0.
- `DEMUX_MSB_FIRST_EN` undefined:
  - `sel` starts at 0 and increments (LSB-first); the first received bit lands in `dout[0]`.
  - The last lane is WIDTH-1.
- Handshake and timing are identical in both builds.

## Structure
- Package `demux_pkg` holds:
  - the state typedef (IDLE, FILL, HOLD);
  - the default-width constant;
  - the lane start and last-lane constants, selected by `DEMUX_MSB_FIRST_EN`.
- Sub-module `demux_sel_cnt` is the lane counter, with these ports:
  - inputs: clock, reset, `load`, `step`;
  - outputs: `sel`, `last`.
- The top level contains the FSM and the per-lane write enables.

## Test plan
- Reset, then send bits 1,0,1,0,0,1,0,1 back to back with `dout_ready`=1 (LSB-first) -> after the 8th accept `dout`=8'hA5 and `dout_valid`=1 for exactly 1 cycle; `sel` sequence 0..7, then 0.
- Same word with random 1-3 cycle `din_valid` gaps -> `dout`=8'hA5; `sel` holds during gaps; `dout_valid` only after the 8th accept.
- Word 8'hA5, then `dout_ready`=0 for 3 cycles while `din_valid`=1, `din`=0 -> `din_ready`=0, `dout` stays 8'hA5. Release `dout_ready` -> next 8 zero bits give `dout`=8'h00.
- Accept 4 bits (1,1,1,1), assert `rst` for 1 cycle -> `dout`=0, `sel`=0, `dout_valid`=0. Then bits 0,1,0,1,0,1,0,1 -> `dout`=8'hAA.
- Bits 1,0,0,0,0,0,0,0 -> `dout`=8'h01 without the macro; `dout`=8'h80 with `DEMUX_MSB_FIRST_EN`, where `sel` runs 7..0.
- Two consecutive words 8'h0F then 8'hF0, with `dout_ready` held at 1 -> exactly one HOLD cycle between words; total 18 cycles.
